ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter ICACHE_IDX_W, default 4, log2 of direct-mapped icache word entries (16).
REQ-002 SHALL have port clk_in  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy_in  input  1  global ready; low freezes all state and outputs.
REQ-005 SHALL have port clear  input  1  pipeline flush from ROB.
REQ-006 SHALL have port if_enable  input  1  decoder fetch request valid.
REQ-007 SHALL have port if_addr  input  32  fetch PC, halfword aligned (bit 0 ignored).
REQ-008 SHALL have port inst_ready  output  1  one-cycle pulse, instruction valid.
REQ-009 SHALL have port is_c  output  1  delivered instruction is 16-bit compressed.
REQ-010 SHALL have port inst_val  output  32  instruction; when is_c, {16'b0, halfword}.
REQ-011 SHALL have port mem_req  output  1  word read request to memctrl.
REQ-012 SHALL have port mem_addr  output  32  word-aligned read address, stable while mem_req.
REQ-013 SHALL have port mem_ready  input  1  one-cycle pulse, mem_data valid.
REQ-014 SHALL have port mem_data  input  32  little-endian word at mem_addr.

Function
REQ-015 SHALL use states IDLE, MISS_LO, MISS_HI; all outputs registered (no combinational path from if_addr to inst_ready).
REQ-016 SHALL, in IDLE with if_enable && !clear, look up word A = if_addr[31:2] and, if if_addr[1]=1 and halfword is 32-bit, word A+1.
REQ-017 SHALL classify halfword h as compressed iff h[1:0] != 2'b11.
REQ-018 SHALL, on full hit, pulse inst_ready in the next cycle and remain IDLE, sustaining one instruction per cycle back-to-back.
REQ-019 SHALL, on miss of A, latch PC, enter MISS_LO, assert mem_req with mem_addr = {A,2'b00} until mem_ready.
REQ-020 SHALL, on mem_ready in MISS_LO, fill entry A; if word A+1 needed and missing enter MISS_HI, else deliver next cycle and return IDLE.
REQ-021 SHALL enter MISS_HI directly from IDLE when A hits but needed A+1 misses.
REQ-022 SHALL compute A+1 modulo 2^30 (PC 0xFFFFFFFE straddles to word 0x00000000).
REQ-023 SHALL assemble straddling instruction as {A+1 word[15:0], A word[31:16]}.
REQ-024 SHALL tag entries with addr[31:2+ICACHE_IDX_W]; valid bits cleared only by reset, never by clear.
REQ-025 SHALL, on clear in any state, go IDLE next cycle, deassert mem_req and inst_ready, discard any same-cycle mem_ready (no cache write), and not accept if_enable that cycle.
REQ-026 SHALL ignore mem_ready outside MISS_LO/MISS_HI.
REQ-027 SHALL, when rdy_in low, hold state, mem_req, mem_addr, and outputs; inst_ready pulse not repeated after rdy_in returns.

Reset
REQ-028 SHALL, while rst_n_in low, force state IDLE, inst_ready 0, is_c 0, inst_val 0, mem_req 0, mem_addr 0, all valid bits 0.
REQ-029 SHALL abandon any in-flight miss on reset; first post-reset fetch misses.

Structure
REQ-030 SHALL place state encoding, ICACHE_IDX_W default and compressed-detect width constants in the shared package.
REQ-031 SHALL implement tag/data/valid storage as one sub-module ifetch_cache (two combinational read ports, one write port).

Verification
REQ-032 SHALL verify cold miss: PC 0x0, word 0x00000513 after 3-cycle mem latency -> one mem_req at 0x0, inst_ready with is_c=0, inst_val 0x00000513.
REQ-033 SHALL verify compressed hit: word 0x45014501 cached, PC 0x0 then 0x2 -> two consecutive inst_ready, is_c=1, inst_val 0x00004501 each, no mem_req.
REQ-034 SHALL verify straddle: PC 0x6, word@0x4=0x0513xxxx (upper half 0x0513), word@0x8=0xxxxx0000 missing -> MISS_HI only, inst_val 0x00000513.
REQ-035 SHALL verify clear during MISS_LO coincident with mem_ready -> no inst_ready, entry remains invalid, refetch on next request.
REQ-036 SHALL verify wrap: PC 0xFFFFFFFE 32-bit -> mem_addr 0xFFFFFFFC then 0x00000000.
REQ-037 SHALL verify rst_n_in asserted mid-MISS_HI -> mem_req low immediately, all valids cleared.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds FSM encoding, cache geometry default and RVC detection.
package ifetch_pkg;

  localparam int ICACHE_IDX_W_DEF = 4;
  localparam int CDET_W = 2;
  localparam logic [CDET_W-1:0] FULL_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MISS_LO = 2'd1,
    MISS_HI = 2'd2
  } if_state_e;

  function automatic logic is_comp(input logic [15:0] h);
    return h[CDET_W-1:0] != FULL_OP;
  endfunction

endpackage

// File: rtl/ifetch_cache.sv
// Direct-mapped word icache: two async read ports, one write port.
// Only the valid bits are reset; tag/data are qualified by them.
module ifetch_cache
  import ifetch_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [29:0] i_ra_addr,
  output logic        o_ra_hit,
  output logic [31:0] o_ra_data,
  input  logic [29:0] i_rb_addr,
  output logic        o_rb_hit,
  output logic [31:0] o_rb_data,
  input  logic        i_we,
  input  logic [29:0] i_w_addr,
  input  logic [31:0] i_w_data
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic [31:0]      r_data [DEPTH];

  logic [IDX_W-1:0] w_ia;
  logic [IDX_W-1:0] w_ib;
  logic [IDX_W-1:0] w_iw;

  assign w_ia = i_ra_addr[IDX_W-1:0];
  assign w_ib = i_rb_addr[IDX_W-1:0];
  assign w_iw = i_w_addr[IDX_W-1:0];

  assign o_ra_hit  = r_valid[w_ia] &&
                     (r_tag[w_ia] == i_ra_addr[29:IDX_W]);
  assign o_ra_data = r_data[w_ia];
  assign o_rb_hit  = r_valid[w_ib] &&
                     (r_tag[w_ib] == i_rb_addr[29:IDX_W]);
  assign o_rb_data = r_data[w_ib];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_iw] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_tag[w_iw]  <= i_w_addr[29:IDX_W];
      r_data[w_iw] <= i_w_data;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: icache lookup, RVC split and line-straddle refill.
// All outputs registered; a fetch may need one or two word refills.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        inst_ready,
  output logic        is_c,
  output logic [31:0] inst_val,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  if_state_e   r_state;
  logic [31:1] r_pc;
  logic        r_inst_ready;
  logic        r_is_c;
  logic [31:0] r_inst_val;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;

  logic [31:1] w_pc;
  logic [29:0] w_wa;
  logic [29:0] w_wb;
  logic        w_ha;
  logic        w_hb;
  logic [31:0] w_da;
  logic [31:0] w_db;
  logic [31:0] w_lo_word;
  logic [15:0] w_lo_half;
  logic        w_comp;
  logic        w_need_b;
  logic [31:0] w_full;
  logic [31:0] w_hi_inst;
  logic        w_fill;
  logic [29:0] w_fill_addr;
  logic        w_unused;

  // In IDLE the cache is probed with the incoming PC, else the latched one
  assign w_pc = (r_state == IDLE) ? if_addr[31:1] : r_pc;
  assign w_wa = w_pc[31:2];
  assign w_wb = w_wa + 30'd1;

  assign w_lo_word = (r_state == MISS_LO) ? mem_data : w_da;
  assign w_lo_half = w_pc[1] ? w_lo_word[31:16] : w_lo_word[15:0];
  assign w_comp    = is_comp(w_lo_half);
  assign w_need_b  = w_pc[1] & ~w_comp;

  always_comb begin
    w_full = w_lo_word;
    if (w_comp) begin
      w_full = {16'b0, w_lo_half};
    end else if (w_pc[1]) begin
      w_full = {w_db[15:0], w_lo_word[31:16]};
    end
  end

  assign w_hi_inst = {mem_data[15:0], w_da[31:16]};

  assign w_fill = rdy_in & ~clear & mem_ready &
                  ((r_state == MISS_LO) | (r_state == MISS_HI));
  assign w_fill_addr = (r_state == MISS_HI) ? w_wb : w_wa;

  assign w_unused = ^{if_addr[0], w_db[31:16]};

  ifetch_cache #(
    .IDX_W(ICACHE_IDX_W)
  ) u_cache (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_ra_addr(w_wa),
    .o_ra_hit (w_ha),
    .o_ra_data(w_da),
    .i_rb_addr(w_wb),
    .o_rb_hit (w_hb),
    .o_rb_data(w_db),
    .i_we     (w_fill),
    .i_w_addr (w_fill_addr),
    .i_w_data (mem_data)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_inst_ready <= 1'b0;
      r_is_c       <= 1'b0;
      r_inst_val   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else if (rdy_in) begin
      r_inst_ready <= 1'b0;
      if (clear) begin
        r_state   <= IDLE;
        r_mem_req <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (if_enable) begin
              r_pc <= if_addr[31:1];
              if (!w_ha) begin
                r_state    <= MISS_LO;
                r_mem_req  <= 1'b1;
                r_mem_addr <= {w_wa, 2'b00};
              end else if (w_need_b && !w_hb) begin
                r_state    <= MISS_HI;
                r_mem_req  <= 1'b1;
                r_mem_addr <= {w_wb, 2'b00};
              end else begin
                r_inst_ready <= 1'b1;
                r_is_c       <= w_comp;
                r_inst_val   <= w_full;
              end
            end
          end
          MISS_LO: begin
            if (mem_ready) begin
              if (w_need_b && !w_hb) begin
                r_state    <= MISS_HI;
                r_mem_addr <= {w_wb, 2'b00};
              end else begin
                r_state      <= IDLE;
                r_mem_req    <= 1'b0;
                r_inst_ready <= 1'b1;
                r_is_c       <= w_comp;
                r_inst_val   <= w_full;
              end
            end
          end
          MISS_HI: begin
            if (mem_ready) begin
              r_state      <= IDLE;
              r_mem_req    <= 1'b0;
              r_inst_ready <= 1'b1;
              r_is_c       <= 1'b0;
              r_inst_val   <= w_hi_inst;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end
        endcase
      end
    end
  end

  assign inst_ready = r_inst_ready;
  assign is_c       = r_is_c;
  assign inst_val   = r_inst_val;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule
